// File: rtl/msg_counter_pkg.sv
// Shared types and helpers for the multi-lane DES plaintext candidate counter.
package msg_counter_pkg;

  localparam int DES_BLOCK_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One bit of headroom so a lane past the top of the counter space compares
  // as out of range instead of wrapping back to zero.
  function automatic logic lane_in_range(input logic [63:0] base,
                                         input logic [4:0]  idx,
                                         input logic [63:0] end_v);
    logic [64:0] lane_val;
    lane_val = {1'b0, base} + {60'd0, idx};
    return lane_val <= {1'b0, end_v};
  endfunction

endpackage

// File: rtl/message_lane.sv
// One candidate lane: {base+idx, region} and whether base+idx is still in range.
module message_lane
  import msg_counter_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 64 - N
) (
  input  logic [CW-1:0]          base,
  input  logic [4:0]             lane_idx,
  input  logic [CW-1:0]          end_reg,
  input  logic [N-1:0]           region_reg,
  output logic [DES_BLOCK_W-1:0] message,
  output logic                   mask
);

  logic [CW-1:0] lane_val;

  assign lane_val = base + CW'(lane_idx);
  assign message  = {lane_val, region_reg};
  assign mask     = lane_in_range(DES_BLOCK_W'(base), lane_idx, DES_BLOCK_W'(end_reg));

endmodule

// File: rtl/message_counter_multilane.sv
// Multi-lane DES plaintext candidate generator with start/end range,
// valid/ready output handshake, tail-beat lane mask and resumable progress.
module message_counter_multilane
  import msg_counter_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 4,
  parameter int CW    = 64 - N
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [N-1:0]                 region_select,
  input  logic [CW-1:0]                start_value,
  input  logic [CW-1:0]                end_value,
  input  logic                         out_ready,
  output logic [DES_BLOCK_W*LANES-1:0] messages,
  output logic [LANES-1:0]             lane_mask,
  output logic                         valid,
  output logic                         busy,
  output logic                         done,
  output logic [CW-1:0]                progress
);

  localparam logic [CW-1:0] STEP     = CW'(LANES);
  localparam logic [CW:0]   LAST_OFS = (CW+1)'(LANES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] base, base_nxt;
  logic [CW-1:0] end_reg, end_nxt;
  logic [N-1:0]  region_reg, region_nxt;
  logic          last_beat;

  logic [DES_BLOCK_W*LANES-1:0] msg_c;
  logic [LANES-1:0]             mask_c;

  assign last_beat = ({1'b0, base} + LAST_OFS) >= {1'b0, end_reg};
  assign progress  = base;

  always_comb begin
    state_nxt  = state;
    base_nxt   = base;
    end_nxt    = end_reg;
    region_nxt = region_reg;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        RUN: begin
          if (valid && out_ready) begin
            if (last_beat) state_nxt = DONE;
            else           base_nxt  = base + STEP;
          end
        end
        IDLE, DONE: begin
          if (start) begin
            region_nxt = region_select;
            base_nxt   = start_value;
            end_nxt    = end_value;
            state_nxt  = (start_value <= end_value) ? RUN : DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Lanes look at the next-cycle base so the beat can be registered in step
  // with the state; without a transfer the inputs are unchanged and the beat holds.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    message_lane #(.N(N), .CW(CW)) u_lane (
      .base       (base_nxt),
      .lane_idx   (5'(i)),
      .end_reg    (end_nxt),
      .region_reg (region_nxt),
      .message    (msg_c[DES_BLOCK_W*i +: DES_BLOCK_W]),
      .mask       (mask_c[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      end_reg    <= '0;
      region_reg <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lane_mask  <= '0;
      messages   <= '0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      end_reg    <= end_nxt;
      region_reg <= region_nxt;
      valid      <= (state_nxt == RUN);
      busy       <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      if (state_nxt == RUN) begin
        messages  <= msg_c;
        lane_mask <= mask_c;
      end else begin
        lane_mask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_message_counter_multilane.sv
// Directed bench for message_counter_multilane with a per-cycle reference model.
module tb_message_counter_multilane;

  localparam int N     = 32;
  localparam int LANES = 4;
  localparam int CW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0]  region_select = '0;
  logic [CW-1:0] start_value = '0;
  logic [CW-1:0] end_value = '0;
  logic [64*LANES-1:0] messages;
  logic [LANES-1:0]    lane_mask;
  logic                valid, busy, done;
  logic [CW-1:0]       progress;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_base[$];
  logic [3:0]  q_mask[$];

  message_counter_multilane #(.N(N), .LANES(LANES)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .region_select (region_select),
    .start_value   (start_value),
    .end_value     (end_value),
    .out_ready     (out_ready),
    .messages      (messages),
    .lane_mask     (lane_mask),
    .valid         (valid),
    .busy          (busy),
    .done          (done),
    .progress      (progress)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is "next counter to hand out" plus an inclusive end.
  bit              m_active, m_done;
  longint unsigned m_next, m_end;
  logic [31:0]     m_region;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_next = 0; m_end = 0; m_region = '0;
    end else if (abort) begin
      m_active = 0; m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_region = region_select;
        m_next   = start_value;
        m_end    = end_value;
        m_active = (start_value <= end_value);
        m_done   = !m_active;
      end
    end else if (out_ready) begin
      if (m_next + LANES - 1 >= m_end) begin
        m_active = 0; m_done = 1;
      end else begin
        m_next += LANES;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0]  exp_mask;
      logic [31:0] ctr;
      for (int i = 0; i < LANES; i++)
        exp_mask[i] = m_active && ((m_next + longint'(i)) <= m_end);
      chk("valid", 64'(valid), 64'(m_active));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      chk("progress", 64'(progress), m_next);
      chk("lane_mask", 64'(lane_mask), 64'(exp_mask));
      if (m_active) begin
        for (int i = 0; i < LANES; i++) begin
          ctr = m_next[31:0] + 32'(i);
          chk("lane_msg", messages[64*i +: 64], {ctr, m_region});
        end
      end
      if (valid && out_ready && !abort) begin
        q_base.push_back(messages[63:32]);
        q_mask.push_back(lane_mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] sv, input logic [31:0] ev, input logic [31:0] rs);
    region_select = rs;
    start_value   = sv;
    end_value     = ev;
    q_base.delete();
    q_mask.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #3;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mask", 64'(lane_mask), 64'd0);
    chk("rst_msg0", messages[63:0], 64'd0);
    chk("rst_progress", 64'(progress), 64'd0);
    #20 rst = 1'b0;
    tick();

    // Plain range 0..9
    out_ready = 1'b1;
    do_start(32'h0, 32'h9, 32'hA5A5_0001);
    wait_done(50);
    chk("r1_beats", 64'(q_base.size()), 64'd3);
    chk("r1_base0", 64'(q_base[0]), 64'h0);
    chk("r1_base1", 64'(q_base[1]), 64'h4);
    chk("r1_base2", 64'(q_base[2]), 64'h8);
    chk("r1_mask0", 64'(q_mask[0]), 64'hF);
    chk("r1_mask1", 64'(q_mask[1]), 64'hF);
    chk("r1_mask2", 64'(q_mask[2]), 64'h3);
    chk("r1_progress", 64'(progress), 64'h8);

    // Backpressure during the second beat
    do_start(32'h0, 32'h9, 32'h0000_0077);
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_lane0", messages[63:0], 64'h0000_0004_0000_0077);
      chk("stall_valid", 64'(valid), 64'd1);
      chk("stall_progress", 64'(progress), 64'h4);
    end
    out_ready = 1'b1;
    wait_done(50);
    chk("stall_beats", 64'(q_base.size()), 64'd3);

    // Top of the counter space
    do_start(32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done(50);
    chk("top_beats", 64'(q_base.size()), 64'd2);
    chk("top_base0", 64'(q_base[0]), 64'hFFFF_FFFA);
    chk("top_base1", 64'(q_base[1]), 64'hFFFF_FFFE);
    chk("top_mask0", 64'(q_mask[0]), 64'hF);
    chk("top_mask1", 64'(q_mask[1]), 64'h3);

    // Empty range
    do_start(32'h10, 32'h0F, 32'h0);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_valid", 64'(valid), 64'd0);
    repeat (3) tick();

    // Abort after five transfers, then resume from progress
    do_start(32'h0, 32'hFF, 32'h0BAD_F00D);
    begin
      int n = 0;
      while (q_base.size() < 5 && n < 100) begin
        tick();
        n++;
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_progress", 64'(progress), 64'h14);
    chk("abort_beats", 64'(q_base.size()), 64'd5);
    do_start(progress, 32'hFF, 32'h0BAD_F00D);
    chk("resume_lane0", messages[63:0], 64'h0000_0014_0BAD_F00D);
    chk("resume_lane1", messages[127:64], 64'h0000_0015_0BAD_F00D);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Region latched at start; start ignored in RUN; async reset mid-cycle
    do_start(32'h0, 32'hFF, 32'hDEAD_BEEF);
    region_select = 32'h0;
    end_value     = 32'h3;
    repeat (2) tick();
    start_value = 32'h999;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("region_lane0", 64'(messages[31:0]), 64'hDEAD_BEEF);
    chk("region_lane3", 64'(messages[223:192]), 64'hDEAD_BEEF);
    chk("ignored_start", 64'(progress), 64'h10);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_mask", 64'(lane_mask), 64'd0);
    chk("arst_progress", 64'(progress), 64'd0);
    chk("arst_msg0", messages[63:0], 64'd0);
    #2 rst = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
